// File: rtl/bias_trim_pkg.sv
// Shared types and parameter defaults for the bias trim controller.
// Holds the sequencing state enum and a small helper used by the top.
package bias_trim_pkg;

  localparam int unsigned NChDefault     = 4;
  localparam int unsigned TrimWDefault   = 6;
  localparam int unsigned RampDivDefault = 16;

  typedef enum logic [1:0] {
    StIdle,
    StEnable,
    StRamp,
    StDone
  } state_e;

  function automatic logic state_busy(input state_e s);
    return (s == StEnable) || (s == StRamp);
  endfunction

endpackage

// File: rtl/bias_trim_shift.sv
// Serial shadow register for trim codes plus a saturating bit counter.
// The counter lets the controller reject loads of partially shifted words.
module bias_trim_shift
  import bias_trim_pkg::*;
#(
  parameter int unsigned Width = NChDefault * TrimWDefault,
  parameter int unsigned CntW  = $clog2(NChDefault * TrimWDefault + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_valid,
  input  logic             sin_data,
  input  logic             load,
  output logic [Width-1:0] shadow,
  output logic [CntW-1:0]  count
);

  // Saturating one past a full word so an over-long shift still fails the load check.
  localparam logic [CntW-1:0] CntMax = CntW'(Width + 1);

  logic [Width-1:0] shadow_q;
  logic [CntW-1:0]  count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      count_q  <= '0;
    end else if (load) begin
      count_q <= '0;
    end else if (sin_valid) begin
      shadow_q <= {shadow_q[Width-2:0], sin_data};
      if (count_q != CntMax) begin
        count_q <= count_q + CntW'(1);
      end
    end
  end

  assign shadow = shadow_q;
  assign count  = count_q;

endmodule

// File: rtl/bias_trim_ctrl.sv
// Bias trim sequencer: staggers channel enables, then ramps DAC codes one LSB per
// tick toward the committed targets, with a sticky error for bad load attempts.
module bias_trim_ctrl
  import bias_trim_pkg::*;
#(
  parameter int unsigned N_CH     = NChDefault,
  parameter int unsigned TRIM_W   = TrimWDefault,
  parameter int unsigned RAMP_DIV = RampDivDefault
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     sin_valid,
  input  logic                     sin_data,
  input  logic                     load,
  input  logic                     err_clr,
  output logic [N_CH*TRIM_W-1:0]   trim_out,
  output logic [N_CH-1:0]          ch_en,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned W    = N_CH * TRIM_W;
  localparam int unsigned CntW = $clog2(W + 2);
  localparam int unsigned DivW = $clog2(RAMP_DIV);

  localparam logic [CntW-1:0]   CntFull = CntW'(W);
  localparam logic [DivW-1:0]   DivLast = DivW'(RAMP_DIV - 1);
  localparam logic [TRIM_W-1:0] TrimOne = TRIM_W'(1);

  state_e          state_q, state_d;
  logic [W-1:0]    target_q, target_d;
  logic [W-1:0]    trim_q, trim_d;
  logic [N_CH-1:0] ch_en_q, ch_en_d;
  logic [DivW-1:0] div_q, div_d;
  logic            err_q, err_d;

  logic [W-1:0]    shadow;
  logic [CntW-1:0] count;
  logic            active;
  logic            load_ok;
  logic            tick;

  bias_trim_shift #(
    .Width (W),
    .CntW  (CntW)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .sin_valid (sin_valid),
    .sin_data  (sin_data),
    .load      (load),
    .shadow    (shadow),
    .count     (count)
  );

  assign active  = state_busy(state_q);
  assign load_ok = load && (count == CntFull) && ((state_q == StIdle) || (state_q == StDone));
  assign tick    = active && ena && (div_q == DivLast);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    trim_d   = trim_q;
    ch_en_d  = ch_en_q;
    div_d    = div_q;
    err_d    = err_q;

    // A fresh error wins over a simultaneous clear.
    if (err_clr) err_d = 1'b0;
    if (load && !load_ok) err_d = 1'b1;

    if (active && ena) begin
      div_d = tick ? '0 : div_q + DivW'(1);
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (load_ok) begin
          target_d = shadow;
          state_d  = (&ch_en_q) ? StRamp : StEnable;
        end
      end
      StEnable: begin
        if (tick) begin
          // x | (x + 1) sets the lowest clear bit.
          ch_en_d = ch_en_q | (ch_en_q + N_CH'(1));
          if (&ch_en_d) state_d = StRamp;
        end
      end
      StRamp: begin
        if (trim_q == target_q) begin
          state_d = StDone;
        end else if (tick) begin
          for (int c = 0; c < int'(N_CH); c++) begin
            if (trim_q[c*TRIM_W +: TRIM_W] < target_q[c*TRIM_W +: TRIM_W]) begin
              trim_d[c*TRIM_W +: TRIM_W] = trim_q[c*TRIM_W +: TRIM_W] + TrimOne;
            end else if (trim_q[c*TRIM_W +: TRIM_W] > target_q[c*TRIM_W +: TRIM_W]) begin
              trim_d[c*TRIM_W +: TRIM_W] = trim_q[c*TRIM_W +: TRIM_W] - TrimOne;
            end
          end
        end
      end
    endcase

    if (state_d != state_q) div_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      target_q <= '0;
      trim_q   <= '0;
      ch_en_q  <= '0;
      div_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      trim_q   <= trim_d;
      ch_en_q  <= ch_en_d;
      div_q    <= div_d;
      err_q    <= err_d;
    end
  end

  assign trim_out = trim_q;
  assign ch_en    = ch_en_q;
  assign busy     = active;
  assign done     = (state_q == StDone);
  assign err      = err_q;

endmodule

// File: doc/bias_trim_ctrl.md
BIAS_TRIM_CTRL -- requirements
Module: bias_trim_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of bias channels.
REQ-002 SHALL have parameter TRIM_W, default 6: trim DAC code width per channel.
REQ-003 SHALL have parameter RAMP_DIV, default 16: clk cycles per ramp/enable tick (>=2).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ena  input  1  tick enable; low freezes sequencing.
REQ-007 SHALL have port sin_valid  input  1  shift strobe for sin_data.
REQ-008 SHALL have port sin_data  input  1  serial trim bit.
REQ-009 SHALL have port load  input  1  commit shadow register as new targets.
REQ-010 SHALL have port err_clr  input  1  clears err.
REQ-011 SHALL have port trim_out  output  N_CH*TRIM_W  live DAC codes, channel c at [c*TRIM_W +: TRIM_W].
REQ-012 SHALL have port ch_en  output  N_CH  per-channel bias enable.
REQ-013 SHALL have port busy  output  1  high in ENABLE or RAMP.
REQ-014 SHALL have port done  output  1  high in DONE.
REQ-015 SHALL have port err  output  1  sticky protocol error.

Function
REQ-016 SHALL shift shadow <= {shadow[N_CH*TRIM_W-2:0], sin_data} on each sin_valid cycle without load; first bit in ends as MSB of channel N_CH-1.
REQ-017 SHALL count shifted bits, saturating at N_CH*TRIM_W+1; count cleared on any load.
REQ-018 SHALL accept shifting in every state (double-buffered against targets).
REQ-019 SHALL give load priority over sin_valid in the same cycle; the concurrent bit is dropped and not counted.
REQ-020 SHALL, on load in IDLE or DONE with count == N_CH*TRIM_W, copy shadow into target and enter ENABLE if ch_en is not all-ones, else RAMP; busy high next cycle.
REQ-021 SHALL, on load with wrong count, set err and leave state, target, trim_out unchanged.
REQ-022 SHALL, on load in ENABLE or RAMP, set err and ignore it.
REQ-023 SHALL clear err only on err_clr; err_clr and a new error in the same cycle leave err set.
REQ-024 SHALL run a tick divider 0..RAMP_DIV-1 only in ENABLE/RAMP with ena high, reset to 0 on state entry; tick when divider == RAMP_DIV-1.
REQ-025 SHALL, in ENABLE, set the lowest clear ch_en bit on each tick; enter RAMP on the tick setting the last bit.
REQ-026 SHALL, in RAMP, on each tick step every channel with trim_out != target by +1 or -1 toward target, no wrap.
REQ-027 SHALL leave RAMP for DONE in the cycle after all channels equal targets (also when equal on entry).
REQ-028 SHALL never clear ch_en except by reset.
REQ-029 SHALL hold divider, ch_en, trim_out while ena low; shifting and load still operate.

Reset
REQ-030 SHALL, while rst high, force state IDLE, trim_out 0, target 0, ch_en 0, busy 0, done 0, err 0, shadow 0, count 0, divider 0, immediately regardless of clk.
REQ-031 SHALL resume from IDLE on the first clk edge after rst deasserts; mid-ramp reset discards all progress.

Structure
REQ-032 SHALL place the state enum (IDLE, ENABLE, RAMP, DONE) and parameter defaults in shared package bias_trim_pkg.
REQ-033 SHALL implement shadow register and bit counter in sub-module bias_trim_shift; FSM, divider and ramp in bias_trim_ctrl.

Verification (N_CH=4, TRIM_W=6, RAMP_DIV=4)
REQ-034 SHALL cover: shift 24 bits for targets ch3..ch0 = 0x05,0x00,0x3F,0x01, load -> ch_en 0001,0011,0111,1111 at ticks 1-4 (16 cycles), then ch1 reaches 0x3F after 63 ticks (252 cycles), done=1, busy=0.
REQ-035 SHALL cover: shift 23 bits, load -> err=1, state IDLE, trim_out 0; err_clr -> err=0.
REQ-036 SHALL cover: from DONE with ch1=0x3F, reload targets ch1=0x3C, others unchanged -> no ENABLE phase, ch1 0x3E,0x3D,0x3C at 4-cycle intervals, done after 3 ticks.
REQ-037 SHALL cover: ena low 10 cycles mid-RAMP -> trim_out and divider frozen; ramp completes 10 cycles later than baseline.
REQ-038 SHALL cover: load pulsed during RAMP -> err=1, targets unchanged, ramp continues to original targets.
REQ-039 SHALL cover: rst asserted mid-RAMP between clk edges -> trim_out=0, ch_en=0, busy=0 without a clk edge.
